sdram32_device_model: RTL and testbench

Synthesizable 32-bit SDR SDRAM device model: the responder on the SDRAM pin interface that `sdram_controller` drives. It decodes pin commands, tracks the mode register and per-bank open rows, and serves read/write bursts from a small on-chip backing array. It flags protocol violations on error outputs. It sits in FPGA-internal loopback builds and in simulation benches, wired to the controller pins with no tri-states.

---
 rtl/sdram32_device_model_if.sv | 21 ++
 rtl/sdram32_device_model.sv | 229 ++++++++++++++++++++++
 tb/tb_sdram32_device_model.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdram32_device_model_if.sv
// SDRAM pin bundle between the controller (master) and the device model (slave).
// Ports: command pins cs_n/ras_n/cas_n/we_n, cke, ba, addr, dqm, dq_in (master->slave);
//        dq_out, dq_oe (slave->master). No tri-states: the data bus is split in/out.
interface sdram32_device_model_if;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic        cke;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [3:0]  dqm;
  logic [31:0] dq_in;
  logic [31:0] dq_out;
  logic        dq_oe;

  modport master (output cs_n, ras_n, cas_n, we_n, cke, ba, addr, dqm, dq_in,
                  input  dq_out, dq_oe);
  modport slave  (input  cs_n, ras_n, cas_n, we_n, cke, ba, addr, dqm, dq_in,
                  output dq_out, dq_oe);
endinterface

// File: rtl/sdram32_device_model.sv
// Purpose: 32-bit SDR SDRAM responder with mode register, per-bank rows, on-chip array.
// Latency: read word k registered at edge E(CL-1+k) after READ at E0; writes land at the edge.
// Backpressure: none; cke=0 freezes the device (command ignored, burst and outputs hold).
// Ports: clk_i, rst_n_i (async active-low), pin (SDRAM pins, slave modport),
//        err_o (1-cycle error pulse), err_code (last error cause), refresh_count.
// Optional: define SDRAM_MODEL_TIMING_CHECK_EN to add TRCD/TRFC checking (error 6).
module sdram32_device_model #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 2,
  parameter int TRFC   = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  sdram32_device_model_if.slave pin,
  output logic                  err_o,
  output logic [2:0]            err_code,
  output logic [15:0]           refresh_count
);
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  logic [31:0] mem_q [2**MEM_AW];

  logic        mode_valid_q, mode_valid_d, cl3_q, cl3_d;
  logic [1:0]  bl_log_q, bl_log_d;
  logic [3:0]  bank_open_q, bank_open_d;
  logic [12:0] bank_row_q [4];
  logic [12:0] bank_row_d [4];
  logic        bst_act_q, bst_act_d, bst_wr_q, bst_wr_d, bst_ap_q, bst_ap_d;
  logic        bst_wait_q, bst_wait_d;
  logic [1:0]  bst_bank_q, bst_bank_d;
  logic [12:0] bst_row_q, bst_row_d;
  logic [9:0]  bst_col_q, bst_col_d;
  logic [3:0]  bst_k_q, bst_k_d;
  logic [3:0]  dqm_p_q, dqm_p_d;
  logic [31:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d, err_o_q, err_o_d;
  logic [2:0]  err_code_q, err_code_d, code;
  logic [15:0] ref_cnt_q, ref_cnt_d;

  logic [3:0]         cmd;
  logic               rw_cmd, start_ok, pre_hit, t_err, mem_we;
  logic [MEM_AW-1:0]  mem_idx;
  logic [3:0]         bl;
  logic [9:0]         col_mask;

  assign cmd      = {pin.cs_n, pin.ras_n, pin.cas_n, pin.we_n};
  assign bl       = 4'd1 << bl_log_q;
  assign col_mask = {6'd0, bl - 4'd1};
  assign rw_cmd   = pin.cke && (cmd == CMD_READ || cmd == CMD_WRITE);
  assign start_ok = rw_cmd && bank_open_q[pin.ba] && mode_valid_q;
  // PRECHARGE hitting the active burst's bank ends the burst without a transfer.
  assign pre_hit  = pin.cke && cmd == CMD_PRE && bst_act_q &&
                    (pin.addr[10] || pin.ba == bst_bank_q);

  // Low burst-column bits wrap modulo BL; upper bits stay on the burst boundary.
  function automatic logic [9:0] burst_col(input logic [9:0] base, input logic [9:0] mask,
                                           input logic [3:0] k);
    return (base & ~mask) | ((base + {6'd0, k}) & mask);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_index(input logic [1:0] b, input logic [12:0] r,
                                                  input logic [9:0] c);
    logic [24:0] full;
    full = {b, r, c};
    return full[MEM_AW-1:0];
  endfunction

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  localparam logic [7:0] TRCD_INIT = 8'(TRCD - 1);
  localparam logic [7:0] TRFC_INIT = 8'(TRFC - 1);
  // Remaining-cycle counters: nonzero means the window is still closed.
  logic [7:0] trcd_q [4];
  logic [7:0] trcd_d [4];
  logic [7:0] trfc_q, trfc_d;

  always_comb begin
    t_err = 1'b0;
    for (int b = 0; b < 4; b++) trcd_d[b] = (trcd_q[b] != 8'd0) ? trcd_q[b] - 8'd1 : 8'd0;
    trfc_d = (trfc_q != 8'd0) ? trfc_q - 8'd1 : 8'd0;
    if (pin.cke) begin
      if (rw_cmd && bank_open_q[pin.ba] && trcd_q[pin.ba] != 8'd0) t_err = 1'b1;
      if (!pin.cs_n && cmd != CMD_NOP && trfc_q != 8'd0) t_err = 1'b1;
      if (cmd == CMD_ACT && !bank_open_q[pin.ba]) trcd_d[pin.ba] = TRCD_INIT;
      if (cmd == CMD_REF && bank_open_q == 4'd0) trfc_d = TRFC_INIT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trcd_q <= '{default: '0};
      trfc_q <= '0;
    end else begin
      trcd_q <= trcd_d;
      trfc_q <= trfc_d;
    end
  end
`else
  logic unused_timing;
  assign unused_timing = (TRCD + TRFC) != 0;
  assign t_err = 1'b0;
`endif

  always_comb begin
    mode_valid_d = mode_valid_q; bl_log_d = bl_log_q; cl3_d = cl3_q;
    bank_open_d = bank_open_q;   bank_row_d = bank_row_q;
    bst_act_d = bst_act_q; bst_wr_d = bst_wr_q; bst_ap_d = bst_ap_q; bst_wait_d = bst_wait_q;
    bst_bank_d = bst_bank_q; bst_row_d = bst_row_q; bst_col_d = bst_col_q; bst_k_d = bst_k_q;
    dqm_p_d = dqm_p_q; dq_out_d = dq_out_q; dq_oe_d = dq_oe_q;
    ref_cnt_d = ref_cnt_q; err_code_d = err_code_q; err_o_d = 1'b0;
    code = 3'd0; mem_we = 1'b0; mem_idx = '0;
    if (pin.cke) begin
      dqm_p_d = pin.dqm;
      dq_oe_d = 1'b0;
      // Advance the running burst unless this edge terminates it.
      if (bst_act_q && !start_ok && !pre_hit) begin
        mem_idx = mem_index(bst_bank_q, bst_row_q, burst_col(bst_col_q, col_mask, bst_k_q));
        if (bst_wr_q) begin
          mem_we  = 1'b1;
          bst_k_d = bst_k_q + 4'd1;
          if (bst_k_q == bl - 4'd1) begin
            bst_act_d = 1'b0;
            if (bst_ap_q) bank_open_d[bst_bank_q] = 1'b0;
          end
        end else if (bst_wait_q) begin
          bst_wait_d = 1'b0;
        end else if (bst_k_q != bl) begin
          for (int b = 0; b < 4; b++)
            dq_out_d[8*b +: 8] = dqm_p_q[b] ? 8'd0 : mem_q[mem_idx][8*b +: 8];
          dq_oe_d = 1'b1;
          bst_k_d = bst_k_q + 4'd1;
        end else begin
          // Edge after the last read word: release the bus, then auto-precharge.
          bst_act_d = 1'b0;
          if (bst_ap_q) bank_open_d[bst_bank_q] = 1'b0;
        end
      end
      case (cmd)
        CMD_ACT: begin
          if (bank_open_q[pin.ba]) code = 3'd1;
          else begin
            bank_open_d[pin.ba] = 1'b1;
            bank_row_d[pin.ba]  = pin.addr;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (!bank_open_q[pin.ba]) code = 3'd2;
          else if (!mode_valid_q)   code = 3'd4;
          else begin
            bst_act_d = 1'b1;           bst_wr_d   = (cmd == CMD_WRITE);
            bst_ap_d  = pin.addr[10];   bst_bank_d = pin.ba;
            bst_row_d = bank_row_q[pin.ba];
            bst_col_d = pin.addr[9:0];  bst_k_d    = 4'd0;
            bst_wait_d = cl3_q;
            if (cmd == CMD_WRITE) begin
              mem_we  = 1'b1;
              mem_idx = mem_index(pin.ba, bank_row_q[pin.ba], pin.addr[9:0]);
              bst_k_d = 4'd1;
              if (bl == 4'd1) begin
                bst_act_d = 1'b0;
                if (pin.addr[10]) bank_open_d[pin.ba] = 1'b0;
              end
            end
          end
        end
        CMD_PRE: begin
          if (pin.addr[10]) bank_open_d = 4'd0;
          else              bank_open_d[pin.ba] = 1'b0;
          if (pre_hit) bst_act_d = 1'b0;
        end
        CMD_REF: begin
          if (bank_open_q != 4'd0) code = 3'd3;
          else                     ref_cnt_d = ref_cnt_q + 16'd1;
        end
        CMD_MRS: begin
          if (!pin.addr[2] && !pin.addr[3] && pin.addr[6:5] == 2'b01) begin
            mode_valid_d = 1'b1;
            bl_log_d     = pin.addr[1:0];
            cl3_d        = pin.addr[4];
          end else begin
            code         = 3'd5;
            mode_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
      if (code == 3'd0 && t_err) code = 3'd6;
      err_o_d = (code != 3'd0);
      if (code != 3'd0) err_code_d = code;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_valid_q <= 1'b0; bl_log_q <= '0; cl3_q <= 1'b0;
      bank_open_q <= '0;    bank_row_q <= '{default: '0};
      bst_act_q <= 1'b0; bst_wr_q <= 1'b0; bst_ap_q <= 1'b0; bst_wait_q <= 1'b0;
      bst_bank_q <= '0; bst_row_q <= '0; bst_col_q <= '0; bst_k_q <= '0;
      dqm_p_q <= '0; dq_out_q <= '0; dq_oe_q <= 1'b0;
      err_o_q <= 1'b0; err_code_q <= '0; ref_cnt_q <= '0;
    end else begin
      mode_valid_q <= mode_valid_d; bl_log_q <= bl_log_d; cl3_q <= cl3_d;
      bank_open_q <= bank_open_d;   bank_row_q <= bank_row_d;
      bst_act_q <= bst_act_d; bst_wr_q <= bst_wr_d; bst_ap_q <= bst_ap_d; bst_wait_q <= bst_wait_d;
      bst_bank_q <= bst_bank_d; bst_row_q <= bst_row_d; bst_col_q <= bst_col_d; bst_k_q <= bst_k_d;
      dqm_p_q <= dqm_p_d; dq_out_q <= dq_out_d; dq_oe_q <= dq_oe_d;
      err_o_q <= err_o_d; err_code_q <= err_code_d; ref_cnt_q <= ref_cnt_d;
    end
  end

  // Backing array is not reset; write DQM applies to the edge's own data.
  always_ff @(posedge clk_i) begin
    if (mem_we && rst_n_i) begin
      for (int b = 0; b < 4; b++)
        if (!pin.dqm[b]) mem_q[mem_idx][8*b +: 8] <= pin.dq_in[8*b +: 8];
    end
  end

  assign pin.dq_out    = dq_out_q;
  assign pin.dq_oe     = dq_oe_q;
  assign err_o         = err_o_q;
  assign err_code      = err_code_q;
  assign refresh_count = ref_cnt_q;
endmodule

// File: tb/tb_sdram32_device_model.sv
// Purpose: directed self-checking bench for sdram32_device_model.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: none; fixed-length directed sequences only.
module tb_sdram32_device_model;
  localparam logic [3:0] NOP = 4'b0111, RD = 4'b0101, WR = 4'b0100, ACT = 4'b0011;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_o;
  logic [2:0]  err_code;
  logic [15:0] refresh_count;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] wd [4];
  logic [31:0] rexp [4];

  sdram32_device_model_if sif ();

  sdram32_device_model dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pin           (sif),
    .err_o         (err_o),
    .err_code      (err_code),
    .refresh_count (refresh_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one command for one rising edge, then return 1 unit after that edge.
  task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    {sif.cs_n, sif.ras_n, sif.cas_n, sif.we_n} = c;
    sif.ba = b; sif.addr = a; sif.dq_in = d; sif.dqm = m; sif.cke = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(NOP, 2'd0, 13'd0, 32'd0, 4'd0);
  endtask

  initial begin
    wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hA1A1_A1A1; wd[2] = 32'hA2A2_A2A2; wd[3] = 32'hA3A3_A3A3;
    {sif.cs_n, sif.ras_n, sif.cas_n, sif.we_n} = NOP;
    sif.cke = 1'b1; sif.ba = '0; sif.addr = '0; sif.dqm = '0; sif.dq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dq_oe", 32'(sif.dq_oe), 32'd0);
    check("rst_dq_out", sif.dq_out, 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_refcnt", 32'(refresh_count), 32'd0);
    rst_n = 1'b1;

    // Mode CL2/BL4, write burst with auto-precharge.
    step(MRS, 2'd0, 13'h022, 32'd0, 4'd0);
    check("mrs_ok", 32'(err_o), 32'd0);
    step(ACT, 2'd1, 13'h055, 32'd0, 4'd0);
    nops(1);
    step(WR, 2'd1, 13'h404, wd[0], 4'd0);
    check("wr_no_err", 32'(err_o), 32'd0);
    for (int k = 1; k < 4; k++) step(NOP, 2'd0, 13'd0, wd[k], 4'd0);
    step(ACT, 2'd1, 13'h055, 32'd0, 4'd0);
    check("wr_ap_closed", 32'(err_o), 32'd0);

    // Read burst wrapping inside the BL4 boundary, auto-precharge after.
    nops(1);
    step(RD, 2'd1, 13'h406, 32'd0, 4'd0);
    check("rd_cmd_err", 32'(err_o), 32'd0);
    check("rd_e0_oe", 32'(sif.dq_oe), 32'd0);
    rexp[0] = wd[2]; rexp[1] = wd[3]; rexp[2] = wd[0]; rexp[3] = wd[1];
    for (int k = 0; k < 4; k++) begin
      nops(1);
      check($sformatf("rd_w%0d_oe", k), 32'(sif.dq_oe), 32'd1);
      check($sformatf("rd_w%0d_dat", k), sif.dq_out, rexp[k]);
    end
    nops(1);
    check("rd_end_oe", 32'(sif.dq_oe), 32'd0);
    step(ACT, 2'd1, 13'h055, 32'd0, 4'd0);
    check("rd_ap_closed", 32'(err_o), 32'd0);

    // Byte-masked writes and read DQM latency.
    nops(1);
    step(WR, 2'd1, 13'h010, 32'h1122_3344, 4'd0);
    for (int k = 1; k < 4; k++) step(NOP, 2'd0, 13'd0, 32'h1122_3344, 4'd0);
    step(WR, 2'd1, 13'h010, 32'hDEAD_BEEF, 4'hE);
    for (int k = 1; k < 4; k++) step(NOP, 2'd0, 13'd0, 32'hFFFF_FFFF, 4'hF);
    step(RD, 2'd1, 13'h010, 32'd0, 4'd0);
    step(NOP, 2'd0, 13'd0, 32'd0, 4'h3);
    check("dqm_wr_w0", sif.dq_out, 32'h1122_33EF);
    nops(1);
    check("dqm_rd_w1", sif.dq_out, 32'h1122_0000);
    nops(1);
    check("dqm_keep_w2", sif.dq_out, 32'h1122_3344);
    nops(2);

    // Closed-bank read and double activate.
    step(PRE, 2'd0, 13'h400, 32'd0, 4'd0);
    step(RD, 2'd0, 13'h000, 32'd0, 4'd0);
    check("closed_err_o", 32'(err_o), 32'd1);
    check("closed_code", 32'(err_code), 32'd2);
    nops(1);
    check("closed_pulse_end", 32'(err_o), 32'd0);
    nops(1);
    check("closed_no_oe", 32'(sif.dq_oe), 32'd0);
    step(ACT, 2'd0, 13'h000, 32'd0, 4'd0);
    check("act0_ok", 32'(err_o), 32'd0);
    step(ACT, 2'd0, 13'h000, 32'd0, 4'd0);
    check("act_twice_code", 32'(err_code), 32'd1);

    // Refresh with banks open, then legal refreshes.
    step(ACT, 2'd2, 13'h000, 32'd0, 4'd0);
    step(REF, 2'd0, 13'h000, 32'd0, 4'd0);
    check("ref_open_err_o", 32'(err_o), 32'd1);
    check("ref_open_code", 32'(err_code), 32'd3);
    check("ref_open_cnt", 32'(refresh_count), 32'd0);
    step(PRE, 2'd0, 13'h400, 32'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(REF, 2'd0, 13'h000, 32'd0, 4'd0);
      nops(8);
    end
    check("ref_cnt3", 32'(refresh_count), 32'd3);
    check("ref_code_held", 32'(err_code), 32'd3);
    check("ref_no_err", 32'(err_o), 32'd0);

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    step(ACT, 2'd1, 13'h055, 32'd0, 4'd0);
    step(RD, 2'd1, 13'h004, 32'd0, 4'd0);
    check("trcd_code", 32'(err_code), 32'd6);
    nops(1);
    check("trcd_data", sif.dq_out, wd[0]);
    nops(4);
    step(PRE, 2'd0, 13'h400, 32'd0, 4'd0);
    step(REF, 2'd0, 13'h000, 32'd0, 4'd0);
    nops(2);
    step(ACT, 2'd0, 13'h000, 32'd0, 4'd0);
    check("trfc_code", 32'(err_code), 32'd6);
    nops(8);
    step(PRE, 2'd0, 13'h400, 32'd0, 4'd0);
`endif

    // Bad mode, read before a valid mode, then CL3/BL2 with a cke freeze.
    step(MRS, 2'd0, 13'h012, 32'd0, 4'd0);
    check("bad_mode_code", 32'(err_code), 32'd5);
    step(ACT, 2'd3, 13'h007, 32'd0, 4'd0);
    nops(1);
    step(RD, 2'd3, 13'h020, 32'd0, 4'd0);
    check("no_mode_code", 32'(err_code), 32'd4);
    step(MRS, 2'd0, 13'h031, 32'd0, 4'd0);
    check("mrs_cl3_ok", 32'(err_o), 32'd0);
    step(WR, 2'd3, 13'h021, 32'h0000_AAAA, 4'd0);
    step(NOP, 2'd0, 13'd0, 32'h0000_BBBB, 4'd0);
    step(RD, 2'd3, 13'h020, 32'd0, 4'd0);
    nops(1);
    check("cl3_wait_oe", 32'(sif.dq_oe), 32'd0);
    nops(1);
    check("cl3_w0", sif.dq_out, 32'h0000_BBBB);
    sif.cke = 1'b0;
    @(posedge clk);
    #1;
    check("cke_hold_dat", sif.dq_out, 32'h0000_BBBB);
    check("cke_hold_oe", 32'(sif.dq_oe), 32'd1);
    nops(1);
    check("cl3_w1", sif.dq_out, 32'h0000_AAAA);
    nops(1);
    check("cl3_end_oe", 32'(sif.dq_oe), 32'd0);

    // Reset in the middle of a read burst.
    step(RD, 2'd3, 13'h020, 32'd0, 4'd0);
    nops(2);
    check("pre_rst_oe", 32'(sif.dq_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(sif.dq_oe), 32'd0);
    check("mid_rst_code", 32'(err_code), 32'd0);
    check("mid_rst_cnt", 32'(refresh_count), 32'd0);
    nops(2);
    rst_n = 1'b1;
    nops(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
